// File: rtl/sm_fetch_buffer.sv
// Instruction prefetch buffer: requests sequential words into a small FIFO ahead of the CPU PC
// and flushes on redirect. Responses owed to flushed requests are counted and dropped.
module sm_fetch_buffer #(
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     AW         = 32,
  parameter logic [AW-1:0]   RESET_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpuAddr,
  output logic [31:0]   cpuData,
  output logic          cpuValid,
  output logic          cpuStall,
  output logic          memReqValid,
  input  logic          memReqReady,
  output logic [AW-1:0] memReqAddr,
  input  logic          memRspValid,
  input  logic [31:0]   memRspData
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Repeated redirects can leave more than DEPTH responses owed, so give discard headroom.
  localparam int unsigned DW = CW + 4;
  localparam logic [CW:0] DepthC = DEPTH[CW:0];

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [CW-1:0] countQ, countD, inflightQ, inflightD;
  logic [DW-1:0] discardQ, discardD;
  logic [AW-1:0] fetchAddrQ, fetchAddrD, expAddrQ, expAddrD;
  logic [CW:0]   occupancy;
  logic          redirect, pop, push, reqFire, rspDrop;

  always_comb begin
    redirect    = (cpuAddr != expAddrQ);
    cpuValid    = !rst && !redirect && (countQ != '0);
    cpuStall    = !cpuValid;
    cpuData     = cpuValid ? mem[rdPtrQ] : '0;
    // Buffered plus in-flight words never exceed DEPTH, so a push always finds space.
    occupancy   = {1'b0, countQ} + {1'b0, inflightQ};
    memReqValid = !rst && !redirect && (occupancy < DepthC);
    memReqAddr  = fetchAddrQ;
    reqFire     = memReqValid && memReqReady;
    pop         = cpuValid;
    rspDrop     = memRspValid && (discardQ != '0);
    push        = memRspValid && (discardQ == '0) && !redirect;
  end

  always_comb begin
    fetchAddrD = fetchAddrQ;
    expAddrD   = expAddrQ;
    rdPtrD     = rdPtrQ;
    wrPtrD     = wrPtrQ;
    countD     = countQ;
    inflightD  = inflightQ;
    discardD   = discardQ;
    if (redirect) begin
      expAddrD   = cpuAddr;
      fetchAddrD = cpuAddr;
      rdPtrD     = '0;
      wrPtrD     = '0;
      countD     = '0;
      inflightD  = '0;
      // Everything still outstanding becomes owed; a response landing now is already dropped.
      discardD   = discardQ + DW'(inflightQ) - DW'(memRspValid);
    end else begin
      if (pop) begin
        expAddrD = expAddrQ + 1'b1;
        rdPtrD   = rdPtrQ + 1'b1;
      end
      if (push) begin
        wrPtrD = wrPtrQ + 1'b1;
      end
      if (reqFire) begin
        fetchAddrD = fetchAddrQ + 1'b1;
      end
      if (rspDrop) begin
        discardD = discardQ - 1'b1;
      end
      countD    = countQ + CW'(push) - CW'(pop);
      inflightD = inflightQ + CW'(reqFire) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchAddrQ <= RESET_ADDR;
      expAddrQ   <= RESET_ADDR;
      rdPtrQ     <= '0;
      wrPtrQ     <= '0;
      countQ     <= '0;
      inflightQ  <= '0;
      discardQ   <= '0;
    end else begin
      fetchAddrQ <= fetchAddrD;
      expAddrQ   <= expAddrD;
      rdPtrQ     <= rdPtrD;
      wrPtrQ     <= wrPtrD;
      countQ     <= countD;
      inflightQ  <= inflightD;
      discardQ   <= discardD;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtrQ] <= memRspData;
    end
  end

endmodule

// File: tb/tb_sm_fetch_buffer.sv
// Bench for sm_fetch_buffer: in-order variable-latency memory model, a CPU driver that
// follows cpuValid and jumps at random, and a scoreboard expecting mem[PC] for every valid word.
module tb_sm_fetch_buffer;
  localparam int unsigned   DEPTH      = 4;
  localparam int unsigned   AW         = 32;
  localparam logic [AW-1:0] RESET_ADDR = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cpuAddr = '0;
  logic [31:0]   cpuData;
  logic          cpuValid, cpuStall, memReqValid;
  logic          memReqReady = 1'b1;
  logic [AW-1:0] memReqAddr;
  logic          memRspValid = 1'b0;
  logic [31:0]   memRspData = '0;

  sm_fetch_buffer #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpuAddr     (cpuAddr),
    .cpuData     (cpuData),
    .cpuValid    (cpuValid),
    .cpuStall    (cpuStall),
    .memReqValid (memReqValid),
    .memReqReady (memReqReady),
    .memReqAddr  (memReqAddr),
    .memRspValid (memRspValid),
    .memRspData  (memRspData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;

  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            memLat = 1;
  int            readyPct = 100;
  int            stallCnt = 0;
  int            accepted = 0;
  int            delivered = 0;
  logic          lastValid = 1'b0;
  logic [AW-1:0] nextReq = RESET_ADDR;
  logic [31:0]   expWord;
  logic [31:0]   expQ[$];
  req_t          pend[$];

  function automatic logic [31:0] memWord(input logic [AW-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Request monitor and memory acceptance; expected request addresses come from the model.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
    end else if (memReqValid && memReqReady) begin
      check("reqAddr", memReqAddr, nextReq);
      nextReq = nextReq + 1'b1;
      accepted++;
      pend.push_back('{addr: memReqAddr, due: cycle + memLat});
    end
  end

  // In-order response driver, one word per cycle at most.
  always @(posedge clk) begin
    #1;
    if (!rst && pend.size() > 0 && pend[0].due <= cycle) begin
      memRspValid = 1'b1;
      memRspData  = memWord(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      memRspValid = 1'b0;
      memRspData  = $urandom;
    end
    memReqReady = ($urandom_range(99) < readyPct);
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    lastValid = cpuValid;
    if (rst) begin
      check("rstCpuValid", cpuValid, 0);
      check("rstCpuStall", cpuStall, 1);
      check("rstMemReqValid", memReqValid, 0);
      check("rstCpuData", cpuData, 0);
    end else begin
      check("stallIsNotValid", cpuStall, !cpuValid);
      if (!cpuValid) begin
        stallCnt++;
      end else if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedValid: got word %0h at addr %0h, required none", cpuData, cpuAddr);
      end else begin
        expWord = expQ.pop_front();
        check("cpuData", cpuData, expWord);
      end
    end
  end

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    cpuAddr  = RESET_ADDR;
    nextReq  = RESET_ADDR;
    stallCnt = 0;
    accepted = 0;
    expQ.delete();
    expQ.push_back(memWord(RESET_ADDR));
  endtask

  // One CPU cycle: advance the PC after a consumed word, or jump.
  task automatic step(input int jumpPct, input bit forceJump, input logic [AW-1:0] tgt);
    logic [AW-1:0] seqAddr, t;
    @(posedge clk);
    #1;
    seqAddr = lastValid ? cpuAddr + 1'b1 : cpuAddr;
    if (lastValid) delivered++;
    if (forceJump || ($urandom_range(99) < jumpPct)) begin
      t = forceJump ? tgt : AW'($urandom_range(0, 1023));
      if (t == seqAddr) t = t + 7;
      if (!lastValid && expQ.size() > 0) void'(expQ.pop_back());
      cpuAddr = t;
      nextReq = t;
      expQ.push_back(memWord(t));
    end else if (lastValid) begin
      cpuAddr = seqAddr;
      expQ.push_back(memWord(seqAddr));
    end
  endtask

  initial begin
    int d0;
    // 1-cycle memory: first word two cycles after reset, then one per cycle.
    memLat = 1;
    readyPct = 100;
    doReset(2);
    d0 = delivered;
    repeat (40) step(0, 1'b0, '0);
    check("stallsAfterReset", stallCnt, 2);
    check("steadyWords", delivered - d0, 38);

    // Latency 5: requests stop at DEPTH outstanding.
    memLat = 5;
    doReset(1);
    repeat (5) @(negedge clk);
    #1;
    check("reqGatedAtDepth", memReqValid, 0);
    check("inflightCap", accepted, DEPTH);
    d0 = delivered;
    repeat (40) step(0, 1'b0, '0);
    check("latency5Words", (delivered - d0) >= 16, 1);

    // Redirect 3 -> 40 with requests outstanding.
    doReset(1);
    for (int i = 0; i < 60 && cpuAddr != 3; i++) step(0, 1'b0, '0);
    check("reachPc3", cpuAddr, 3);
    step(0, 1'b1, 40);
    d0 = delivered;
    repeat (20) step(0, 1'b0, '0);
    check("wordsAfterRedirect", (delivered - d0) >= 5, 1);

    // Redirects colliding with responses and refused requests.
    memLat = 1;
    readyPct = 50;
    repeat (300) step(30, 1'b0, '0);

    // Address wrap.
    readyPct = 100;
    step(0, 1'b1, {AW{1'b1}} - 1'b1);
    repeat (12) step(0, 1'b0, '0);
    check("wrapPc", cpuAddr < 16, 1);

    // Random mix with occasional mid-run resets.
    d0 = delivered;
    for (int c = 0; c < 15; c++) begin
      memLat   = $urandom_range(1, 6);
      readyPct = $urandom_range(30, 100);
      if ($urandom_range(2) == 0) doReset($urandom_range(1, 2));
      repeat (200) step(5, 1'b0, '0);
    end
    check("randomLiveness", (delivered - d0) >= 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
